// File: rtl/ita_softmax_div_sched.sv
// Softmax divider scheduler: spreads exp-sum operands round-robin over NUM_DIV
// serial dividers and writes their results back in issue order.
module ita_softmax_div_sched #(
  parameter int NUM_DIV = 4,
  parameter int DATA_W  = 24,
  parameter int RES_W   = 24,
  parameter int ROW_LEN = 64,
  localparam int ADDR_W = $clog2(ROW_LEN)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [15:0]              num_rows_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [DATA_W-1:0]        req_data_i,
  output logic [NUM_DIV-1:0]       div_valid_o,
  input  logic [NUM_DIV-1:0]       div_ready_i,
  output logic [DATA_W-1:0]        div_data_o,
  input  logic [NUM_DIV-1:0]       div_valid_i,
  output logic [NUM_DIV-1:0]       div_ready_o,
  input  logic [NUM_DIV*RES_W-1:0] div_result_i,
  output logic                     wr_en_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [RES_W-1:0]         wr_data_o,
  output logic                     row_done_o,
  output logic                     job_done_o,
  output logic                     busy_o
);

  localparam int PTR_W = $clog2(NUM_DIV);
  localparam int CNT_W = 16 + ADDR_W;
  localparam logic [PTR_W:0] MAX_OUT = (PTR_W+1)'(NUM_DIV);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [PTR_W-1:0]  iss_ptr, ret_ptr;
  logic [PTR_W:0]    outstanding;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       rows_left;
  logic [15:0]       rows_init;
  logic [CNT_W-1:0]  issued_total, issue_limit;
  logic [RES_W-1:0]  results [NUM_DIV];
  logic              running, can_issue, issue, ret, last_addr;

  assign running   = (state == RUN);
  assign can_issue = running && (outstanding < MAX_OUT) && (issued_total < issue_limit);
  assign req_ready_o = can_issue && div_ready_i[iss_ptr];
  assign issue     = req_valid_i && req_ready_o;
  assign ret       = running && div_valid_i[ret_ptr];
  assign last_addr = (addr_q == LAST_ADDR);
  assign rows_init = (num_rows_i == 16'd0) ? 16'd1 : num_rows_i;
  assign div_data_o = req_data_i;
  assign busy_o     = (state != IDLE);
  assign job_done_o = (state == DONE);

  // Only the divider at ret_ptr is ever acknowledged, which keeps results in issue order.
  for (genvar gi = 0; gi < NUM_DIV; gi++) begin : g_div
    assign results[gi]     = div_result_i[gi*RES_W +: RES_W];
    assign div_valid_o[gi] = can_issue && req_valid_i && (iss_ptr == PTR_W'(gi));
    assign div_ready_o[gi] = running && (ret_ptr == PTR_W'(gi));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // The job ends in the cycle that shows the final write, after the last row was counted off.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = RUN;
      RUN:     if (row_done_o && rows_left == 16'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iss_ptr      <= '0;
      ret_ptr      <= '0;
      outstanding  <= '0;
      addr_q       <= '0;
      rows_left    <= '0;
      issued_total <= '0;
      issue_limit  <= '0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      row_done_o   <= 1'b0;
    end else begin
      wr_en_o    <= ret;
      row_done_o <= ret && last_addr;
      if (ret) begin
        wr_addr_o <= addr_q;
        wr_data_o <= results[ret_ptr];
      end
      if (state == IDLE && start_i) begin
        iss_ptr      <= '0;
        ret_ptr      <= '0;
        outstanding  <= '0;
        addr_q       <= '0;
        issued_total <= '0;
        rows_left    <= rows_init;
        issue_limit  <= CNT_W'(rows_init) * CNT_W'(ROW_LEN);
      end else begin
        if (issue) begin
          iss_ptr      <= iss_ptr + PTR_W'(1);
          issued_total <= issued_total + CNT_W'(1);
        end
        if (ret) begin
          ret_ptr <= ret_ptr + PTR_W'(1);
          addr_q  <= last_addr ? '0 : addr_q + ADDR_W'(1);
          if (last_addr) rows_left <= rows_left - 16'd1;
        end
        case ({issue, ret})
          2'b10:   outstanding <= outstanding + (PTR_W+1)'(1);
          2'b01:   outstanding <= outstanding - (PTR_W+1)'(1);
          default: outstanding <= outstanding;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ita_softmax_div_sched.sv
// Directed bench for ita_softmax_div_sched: streamed jobs against a latency-3
// divider model, then hand-driven out-of-order, saturation and reset cases.
`timescale 1ns/1ps
module tb_ita_softmax_div_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_rows = 16'd0;
  logic        req_valid = 1'b0;
  logic [23:0] req_data = 24'd0;
  logic        req_ready;
  logic [3:0]  div_valid_out;
  logic [3:0]  dready = 4'hF;
  logic [23:0] div_data;
  logic [3:0]  div_valid_in;
  logic [3:0]  div_ready_out;
  logic [95:0] div_result;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [23:0] wr_data;
  logic        row_done, job_done, busy;

  ita_softmax_div_sched dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_rows_i(num_rows),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .div_valid_o(div_valid_out), .div_ready_i(dready), .div_data_o(div_data),
    .div_valid_i(div_valid_in), .div_ready_o(div_ready_out), .div_result_i(div_result),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .row_done_o(row_done), .job_done_o(job_done), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Divider model: accepts whenever offered, answers operand ^ 5A5A5A three edges later.
  logic        auto_mode = 1'b1;
  logic [3:0]  m_hold;
  logic [1:0]  m_timer [4];
  logic [23:0] m_op [4];
  logic [3:0]  m_valid;
  logic [95:0] m_res;
  logic [3:0]  man_valid = 4'h0;
  logic [95:0] man_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst || !auto_mode) begin
      m_hold <= 4'h0;
      for (int d = 0; d < 4; d++) begin
        m_timer[d] <= 2'd0;
        m_op[d]    <= 24'd0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (m_hold[d] && m_timer[d] == 2'd0 && div_ready_out[d]) m_hold[d] <= 1'b0;
        else if (m_hold[d] && m_timer[d] != 2'd0) m_timer[d] <= m_timer[d] - 2'd1;
        if (!m_hold[d] && div_valid_out[d]) begin
          m_hold[d]  <= 1'b1;
          m_timer[d] <= 2'd2;
          m_op[d]    <= div_data;
        end
      end
    end
  end

  always_comb begin
    m_valid = 4'h0;
    m_res   = '0;
    for (int d = 0; d < 4; d++) begin
      m_valid[d]          = m_hold[d] && (m_timer[d] == 2'd0);
      m_res[d*24 +: 24]   = m_op[d] ^ 24'h5A5A5A;
    end
  end

  assign div_valid_in = auto_mode ? m_valid : man_valid;
  assign div_result   = auto_mode ? m_res : man_res;

  // Write-port monitor, sampled on the falling edge.
  logic [5:0]  log_addr [$];
  logic [23:0] log_data [$];
  int cyc = 0, row_cnt = 0, row_bad = 0, job_cnt = 0, last_row_cyc = 0, job_cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    if (row_done) begin
      row_cnt      <= row_cnt + 1;
      last_row_cyc <= cyc + 1;
      if (!(wr_en && wr_addr == 6'd63)) row_bad <= row_bad + 1;
    end
    if (job_done) begin
      job_cnt <= job_cnt + 1;
      job_cyc <= cyc + 1;
    end
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({req_ready, div_valid_out, div_ready_out, wr_en, wr_addr, wr_data,
                row_done, job_done, busy});
  endfunction

  task automatic run_job(input logic [15:0] nrows, input int exp_rows, input int opb);
    int exp_n, issued, base, rd0, jd0, rb0, budget, lim_bad, bad;
    exp_n = exp_rows * 64;
    base = log_addr.size();
    rd0 = row_cnt; jd0 = job_cnt; rb0 = row_bad;
    issued = 0; budget = 0; lim_bad = 0; bad = 0;
    auto_mode = 1'b1;
    man_valid = 4'h0;
    @(negedge clk); start = 1'b1; num_rows = nrows;
    @(negedge clk); start = 1'b0;
    while (job_cnt == jd0 && budget < 5000) begin
      req_valid = 1'b1;
      req_data  = 24'(opb + issued);
      #1;
      if (issued == exp_n) begin
        if (req_ready) lim_bad++;
      end else if (req_ready) issued++;
      @(negedge clk);
      budget++;
    end
    req_valid = 1'b0;
    chk("job_timeout", 64'(budget < 5000), 64'd1);
    chk("issue_count", 64'(issued), 64'(exp_n));
    chk("ready_after_limit", 64'(lim_bad), 64'd0);
    chk("write_count", 64'(log_addr.size() - base), 64'(exp_n));
    for (int i = 0; i < exp_n && base + i < log_addr.size(); i++) begin
      if (log_addr[base+i] !== 6'(i % 64) ||
          log_data[base+i] !== (24'(opb + i) ^ 24'h5A5A5A)) bad++;
    end
    chk("write_order_data", 64'(bad), 64'd0);
    chk("row_done_count", 64'(row_cnt - rd0), 64'(exp_rows));
    chk("row_done_on_last", 64'(row_bad - rb0), 64'd0);
    chk("job_done_count", 64'(job_cnt - jd0), 64'd1);
    chk("job_after_row", 64'(job_cyc - last_row_cyc), 64'd1);
    @(negedge clk);
    chk("busy_after_job", 64'(busy), 64'd0);
  endtask

  task automatic issue_one(input logic [23:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = d;
    #1;
    chk("man_issue_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic ret_one(input int idx, input logic [23:0] res, input logic [5:0] addr);
    @(negedge clk);
    man_valid[idx] = 1'b1;
    man_res[idx*24 +: 24] = res;
    @(negedge clk);
    man_valid[idx] = 1'b0;
    chk("man_wr_en", 64'(wr_en), 64'd1);
    chk("man_wr_addr", 64'(wr_addr), 64'(addr));
    chk("man_wr_data", 64'(wr_data), 64'(res));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;

    run_job(16'd1, 1, 24'h000100);
    run_job(16'd3, 3, 24'h010000);
    run_job(16'd0, 1, 24'h020000);

    // Hand-driven dividers: divider 1 answers before divider 0.
    auto_mode = 1'b0;
    @(negedge clk); start = 1'b1; num_rows = 16'd1;
    @(negedge clk); start = 1'b0;
    issue_one(24'h00AAAA);
    issue_one(24'h00BBBB);
    @(negedge clk);
    man_valid[1] = 1'b1;
    man_res[24 +: 24] = 24'h111111;
    repeat (2) @(negedge clk);
    chk("ooo_ready_onehot", 64'(div_ready_out), 64'h1);
    chk("ooo_no_write", 64'(wr_en), 64'd0);
    ret_one(0, 24'h000AAA, 6'd0);
    @(negedge clk);
    man_valid[1] = 1'b0;
    chk("ooo_second_en", 64'(wr_en), 64'd1);
    chk("ooo_second_addr", 64'(wr_addr), 64'd1);
    chk("ooo_second_data", 64'(wr_data), 64'h111111);

    // Saturation: four outstanding blocks issue until a return frees a slot.
    issue_one(24'h000002);
    issue_one(24'h000003);
    issue_one(24'h000004);
    issue_one(24'h000005);
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = 24'h000006;
    #1;
    chk("sat_ready_low", 64'(req_ready), 64'd0);
    chk("sat_valid_low", 64'(div_valid_out), 64'd0);
    chk("div_data_bus", 64'(div_data), 64'h000006);
    req_valid = 1'b0;
    ret_one(2, 24'h222222, 6'd2);
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = 24'h000006;
    man_valid[3] = 1'b1;
    man_res[72 +: 24] = 24'h333333;
    #1;
    chk("sim_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    man_valid[3] = 1'b0;
    chk("sim_wr_addr", 64'(wr_addr), 64'd3);
    chk("sim_wr_data", 64'(wr_data), 64'h333333);
    @(negedge clk);
    req_valid = 1'b1;
    #1;
    chk("sim_count_held", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b1;
    #1;
    chk("refill_ready_low", 64'(req_ready), 64'd0);
    req_valid = 1'b0;

    // Abort mid-job with results still pending.
    man_valid = 4'hF;
    rst = 1'b1;
    #1;
    chk("abort_outputs", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    man_valid = 4'h0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_wr_en", 64'(wr_en), 64'd0);
    chk("post_reset_busy", 64'(busy), 64'd0);
    run_job(16'd1, 1, 24'h030000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
